// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the chunked ripple-carry add/subtract unit.
package multi_cycle_adder_pkg;

    // Operation sequencing: accept, walk the chunks, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Chunk counter width; one spare bit so N itself is representable.
    function automatic int cnt_width(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// Operand/result handshake bundle for multi_cycle_adder.
interface multi_cycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side of the unit.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/multi_cycle_adder_full_adder.sv
// One-bit full adder; a chain of these forms the per-cycle chunk adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ cin_i;
    assign carry_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/multi_cycle_adder.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock through a registered
// carry; one operation in flight, valid/ready on both sides.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_cycle_adder_if.slave  mca
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH || WIDTH < 2) begin : g_param_chk
        $fatal(1, "multi_cycle_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;      // operands, consumed from the LSB end
    logic [WIDTH-1:0] acc_q, acc_d;  // partial sum, filled from the MSB end
    logic [WIDTH-1:0] sum_q;         // last completed result
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cout_q, ovf_q;
    logic             in_ready_q, out_valid_q;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] chunk_s;
    logic             last;

    // Ripple chain across the low CHUNK bits of the operand registers.
    assign c[0] = carry_q;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a_i     (a_q[i]),
            .b_i     (b_q[i]),
            .cin_i   (c[i]),
            .sum_o   (chunk_s[i]),
            .carry_o (c[i+1])
        );
    end

    assign last = (cnt_q == CNT_W'(N - 1));

    // Shift the new chunk in at the top so after N steps the LSB chunk lands at bit 0.
    always_comb begin
        acc_d = (acc_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
    end

    // Sequencer and datapath state; outputs are registered here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mca.in_valid && in_ready_q) begin
                        // Subtract is a + ~b + 1; cin only matters when adding.
                        a_q        <= mca.a;
                        b_q        <= mca.sub ? ~mca.b : mca.b;
                        carry_q    <= mca.sub ? 1'b1 : mca.cin;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= c[CHUNK];
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last) begin
                        // Result only becomes visible here, so sum holds the
                        // previous answer throughout the run.
                        sum_q       <= acc_d;
                        cout_q      <= c[CHUNK];
                        ovf_q       <= c[CHUNK] ^ c[CHUNK-1];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (mca.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mca.in_ready  = in_ready_q;
    assign mca.out_valid = out_valid_q;
    assign mca.sum       = sum_q;
    assign mca.cout      = cout_q;
    assign mca.ovf       = ovf_q;

endmodule
